// File: rtl/bmp280_spi_slave_emu.sv
// BMP280 register-map emulator behind an SPI mode-0 responder, fed by fabric ADC samples.
// Defining BMP280_EMU_STATS_EN adds the txn_count/err_count transaction statistics outputs.
module bmp280_spi_slave_emu #(
  parameter int unsigned CLK_HZ        = 25000000,
  parameter logic [7:0]  CHIP_ID       = 8'h58,
  parameter int unsigned MEAS_CYCLES   = CLK_HZ / 200,
  parameter int unsigned NORMAL_PERIOD = CLK_HZ / 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_csn,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  input  logic [19:0] adc_t,
  input  logic [19:0] adc_p,
  output logic        meas_done,
  output logic        soft_reset,
  output logic [7:0]  ctrl_meas,
  output logic [7:0]  config_reg
`ifdef BMP280_EMU_STATS_EN
  ,
  output logic [15:0] txn_count,
  output logic [7:0]  err_count
`endif
);

  localparam int unsigned MEAS_W   = $clog2(MEAS_CYCLES + 1);
  localparam int unsigned PER_W    = $clog2(NORMAL_PERIOD + 1);
  localparam int unsigned ADC_W    = 20;
  localparam logic [ADC_W-1:0] DATA_RST = 20'h80000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_RDATA,
    S_WDATA
  } state_t;

  state_t state_q, state_d;

  logic [1:0] csn_sync_q, sck_sync_q, mosi_sync_q;
  logic       csn_d_q, sck_d_q;
  logic       csn_s, sck_s, mosi_s;
  logic       csn_fall_c, csn_rise_c, sck_rise_c, sck_fall_c;

  logic [2:0] bit_cnt_q;
  logic [6:0] rx_sr_q;
  logic [7:0] rx_byte_c;
  logic [7:0] addr_q;
  logic [7:0] tx_sr_q;
  logic [7:0] rd_addr_c;
  logic [7:0] rd_data_c;
  logic       byte_end_c;
  logic       wr_stb_c;

  logic [ADC_W-1:0] press_q, temp_q;
  logic [ADC_W-1:0] shadow_p_q, shadow_t_q;
  logic             measuring_q;
  logic [MEAS_W-1:0] meas_cnt_q;
  logic [PER_W-1:0]  per_cnt_q;

  logic wr_f4_c, wr_f5_c, srst_c;
  logic complete_c, tick_c, can_start_c;

  // Input synchronisers and edge detection on the synchronised copies
  always_ff @(posedge clk) begin
    if (rst) begin
      csn_sync_q  <= 2'b11;
      sck_sync_q  <= 2'b00;
      mosi_sync_q <= 2'b00;
      csn_d_q     <= 1'b1;
      sck_d_q     <= 1'b0;
    end else begin
      csn_sync_q  <= {csn_sync_q[0], spi_csn};
      sck_sync_q  <= {sck_sync_q[0], spi_sck};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      csn_d_q     <= csn_sync_q[1];
      sck_d_q     <= sck_sync_q[1];
    end
  end

  assign csn_s      = csn_sync_q[1];
  assign sck_s      = sck_sync_q[1];
  assign mosi_s     = mosi_sync_q[1];
  assign csn_fall_c = csn_d_q & ~csn_s;
  assign csn_rise_c = ~csn_d_q & csn_s;
  assign sck_rise_c = ~sck_d_q & sck_s;
  assign sck_fall_c = sck_d_q & ~sck_s;

  assign rx_byte_c = {rx_sr_q, mosi_s};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and per-byte strobes; CSN rising always wins
  always_comb begin
    state_d    = state_q;
    byte_end_c = 1'b0;
    wr_stb_c   = 1'b0;
    if (state_q != S_IDLE && sck_rise_c && bit_cnt_q == 3'd7 && !csn_rise_c) byte_end_c = 1'b1;
    case (state_q)
      S_IDLE:  if (csn_fall_c) state_d = S_ADDR;
      S_ADDR:  if (byte_end_c) state_d = rx_byte_c[7] ? S_RDATA : S_WDATA;
      S_RDATA: state_d = S_RDATA;
      S_WDATA: begin
        if (byte_end_c) begin
          state_d  = S_ADDR;
          wr_stb_c = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && csn_rise_c) state_d = S_IDLE;
  end

  // During the command byte the read index comes straight from the incoming byte
  assign rd_addr_c = (state_q == S_ADDR) ? {1'b1, rx_byte_c[6:0]} : addr_q;

  // Register read mux; 0xF7-0xFC come from the per-transaction shadow
  always_comb begin
    rd_data_c = 8'h00;
    case (rd_addr_c)
      8'h88: rd_data_c = 8'h70;
      8'h89: rd_data_c = 8'h6B;
      8'h8A: rd_data_c = 8'h53;
      8'h8B: rd_data_c = 8'h67;
      8'h8C: rd_data_c = 8'h18;
      8'h8D: rd_data_c = 8'hFC;
      8'h8E: rd_data_c = 8'h7D;
      8'h8F: rd_data_c = 8'h8E;
      8'h90: rd_data_c = 8'h43;
      8'h91: rd_data_c = 8'hD6;
      8'h92: rd_data_c = 8'hD0;
      8'h93: rd_data_c = 8'h0B;
      8'h94: rd_data_c = 8'h27;
      8'h95: rd_data_c = 8'h0B;
      8'h96: rd_data_c = 8'h8C;
      8'h97: rd_data_c = 8'h00;
      8'h98: rd_data_c = 8'hF9;
      8'h99: rd_data_c = 8'hFF;
      8'h9A: rd_data_c = 8'h8C;
      8'h9B: rd_data_c = 8'h3C;
      8'h9C: rd_data_c = 8'hF8;
      8'h9D: rd_data_c = 8'hC6;
      8'h9E: rd_data_c = 8'h70;
      8'h9F: rd_data_c = 8'h17;
      8'hD0: rd_data_c = CHIP_ID;
      8'hF3: rd_data_c = {4'h0, measuring_q, 3'b000};
      8'hF4: rd_data_c = ctrl_meas;
      8'hF5: rd_data_c = config_reg;
      8'hF7: rd_data_c = shadow_p_q[19:12];
      8'hF8: rd_data_c = shadow_p_q[11:4];
      8'hF9: rd_data_c = {shadow_p_q[3:0], 4'h0};
      8'hFA: rd_data_c = shadow_t_q[19:12];
      8'hFB: rd_data_c = shadow_t_q[11:4];
      8'hFC: rd_data_c = {shadow_t_q[3:0], 4'h0};
      default: rd_data_c = 8'h00;
    endcase
  end

  // SPI shift path: RX on synced SCK rise, TX on synced SCK fall
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= 3'd0;
      rx_sr_q     <= 7'd0;
      addr_q      <= 8'h00;
      tx_sr_q     <= 8'h00;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      shadow_p_q  <= DATA_RST;
      shadow_t_q  <= DATA_RST;
    end else if (state_q == S_IDLE) begin
      if (csn_fall_c) begin
        bit_cnt_q   <= 3'd0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b1;
        shadow_p_q  <= press_q;
        shadow_t_q  <= temp_q;
      end
    end else if (csn_rise_c) begin
      bit_cnt_q   <= 3'd0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else if (sck_rise_c) begin
      rx_sr_q   <= rx_byte_c[6:0];
      bit_cnt_q <= bit_cnt_q + 3'd1;
      if (byte_end_c) begin
        if (state_q == S_ADDR && !rx_byte_c[7]) begin
          addr_q <= rd_addr_c;
        end else if (state_q != S_WDATA) begin
          tx_sr_q <= rd_data_c;
          addr_q  <= {1'b1, 7'(rd_addr_c[6:0] + 7'd1)};
        end
      end
    end else if (sck_fall_c && state_q == S_RDATA) begin
      spi_miso <= tx_sr_q[7];
      tx_sr_q  <= {tx_sr_q[6:0], 1'b0};
    end
  end

  assign wr_f4_c     = wr_stb_c && addr_q == 8'hF4;
  assign wr_f5_c     = wr_stb_c && addr_q == 8'hF5;
  assign srst_c      = wr_stb_c && addr_q == 8'hE0 && rx_byte_c == 8'hB6;
  assign complete_c  = measuring_q && meas_cnt_q == MEAS_W'(1);
  assign tick_c      = ctrl_meas[1:0] == 2'b11 && per_cnt_q == PER_W'(1);
  assign can_start_c = !measuring_q || complete_c;

  // Measurement engine; later assignments give the 0xF4 write priority over completion
  always_ff @(posedge clk) begin
    if (rst || srst_c) begin
      ctrl_meas   <= 8'h00;
      config_reg  <= 8'h00;
      measuring_q <= 1'b0;
      meas_cnt_q  <= '0;
      per_cnt_q   <= '0;
      press_q     <= DATA_RST;
      temp_q      <= DATA_RST;
      meas_done   <= 1'b0;
    end else begin
      meas_done <= 1'b0;
      if (measuring_q) meas_cnt_q <= meas_cnt_q - MEAS_W'(1);
      if (complete_c) begin
        measuring_q <= 1'b0;
        press_q     <= adc_p;
        temp_q      <= adc_t;
        meas_done   <= 1'b1;
        if (ctrl_meas[1:0] != 2'b11) ctrl_meas <= {ctrl_meas[7:2], 2'b00};
      end
      if (ctrl_meas[1:0] == 2'b11 && per_cnt_q != '0) per_cnt_q <= per_cnt_q - PER_W'(1);
      if (tick_c) begin
        per_cnt_q <= PER_W'(NORMAL_PERIOD);
        if (can_start_c) begin
          measuring_q <= 1'b1;
          meas_cnt_q  <= MEAS_W'(MEAS_CYCLES);
        end
      end
      if (wr_f4_c) begin
        ctrl_meas <= rx_byte_c;
        case (rx_byte_c[1:0])
          2'b00: measuring_q <= 1'b0;
          2'b11: begin
            per_cnt_q <= PER_W'(NORMAL_PERIOD);
            if (can_start_c) begin
              measuring_q <= 1'b1;
              meas_cnt_q  <= MEAS_W'(MEAS_CYCLES);
            end
          end
          default: begin
            measuring_q <= 1'b1;
            meas_cnt_q  <= MEAS_W'(MEAS_CYCLES);
          end
        endcase
      end
      if (wr_f5_c) config_reg <= rx_byte_c & 8'hFD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) soft_reset <= 1'b0;
    else     soft_reset <= srst_c;
  end

`ifdef BMP280_EMU_STATS_EN
  logic had_byte_q;

  // Transaction and partial-byte error counters, evaluated on each CSN rise
  always_ff @(posedge clk) begin
    if (rst || srst_c) begin
      txn_count  <= 16'd0;
      err_count  <= 8'd0;
      had_byte_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && csn_fall_c) had_byte_q <= 1'b0;
      else if (byte_end_c)                 had_byte_q <= 1'b1;
      if (state_q != S_IDLE && csn_rise_c) begin
        if (had_byte_q) txn_count <= txn_count + 16'd1;
        if (bit_cnt_q != 3'd0 && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bmp280_spi_slave_emu.sv
// Directed bench for bmp280_spi_slave_emu: SPI master tasks plus hand-computed register expectations.
module tb_bmp280_spi_slave_emu;

  localparam int unsigned MEAS = 600;
  localparam int unsigned NPER = 4000;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_csn = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe;
  logic [19:0] adc_t = 20'h0;
  logic [19:0] adc_p = 20'h0;
  logic        meas_done, soft_reset;
  logic [7:0]  ctrl_meas, config_reg;
`ifdef BMP280_EMU_STATS_EN
  logic [15:0] txn_count;
  logic [7:0]  err_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int srst_pulses = 0;
  int done_pulses = 0;
  logic [7:0] rbuf [0:31];
  logic [7:0] b;
  logic [7:0] cal [0:23];
  int t0, t1, base;
  logic seen;

  bmp280_spi_slave_emu #(
    .MEAS_CYCLES  (MEAS),
    .NORMAL_PERIOD(NPER)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_csn    (spi_csn),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .adc_t      (adc_t),
    .adc_p      (adc_p),
    .meas_done  (meas_done),
    .soft_reset (soft_reset),
    .ctrl_meas  (ctrl_meas),
    .config_reg (config_reg)
`ifdef BMP280_EMU_STATS_EN
    ,
    .txn_count  (txn_count),
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (soft_reset) srst_pulses++;
    if (meas_done)  done_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cs_low();
    spi_csn = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (H) @(negedge clk);
    spi_csn = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  // Mode-0 master: MOSI set while SCK low, MISO sampled just before SCK rises
  task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = tx[i];
      repeat (H) @(negedge clk);
      rx[i] = spi_miso;
      spi_sck = 1'b1;
      repeat (H) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_read(input logic [7:0] idx, input int n);
    logic [7:0] d;
    cs_low();
    xfer_bits({1'b1, idx[6:0]}, 8, d);
    for (int k = 0; k < n; k++) begin
      xfer_bits(8'h00, 8, d);
      rbuf[k] = d;
    end
    cs_high();
  endtask

  task automatic spi_write(input logic [7:0] idx, input logic [7:0] data);
    logic [7:0] d;
    cs_low();
    xfer_bits({1'b0, idx[6:0]}, 8, d);
    xfer_bits(data, 8, d);
    cs_high();
  endtask

  initial begin
    cal = '{8'h70, 8'h6B, 8'h53, 8'h67, 8'h18, 8'hFC, 8'h7D, 8'h8E, 8'h43, 8'hD6, 8'hD0, 8'h0B,
            8'h27, 8'h0B, 8'h8C, 8'h00, 8'hF9, 8'hFF, 8'h8C, 8'h3C, 8'hF8, 8'hC6, 8'h70, 8'h17};

    // Reset state
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso", spi_miso, 0);
    chk("rst_oe", spi_miso_oe, 0);
    chk("rst_meas_done", meas_done, 0);
    chk("rst_soft_reset", soft_reset, 0);
    chk("rst_ctrl_meas", ctrl_meas, 8'h00);
    chk("rst_config", config_reg, 8'h00);

    // Chip ID read, MISO quiet during the command byte
    cs_low();
    chk("id_oe_active", spi_miso_oe, 1);
    xfer_bits(8'hD0, 8, b);
    chk("id_cmd_miso_zero", b, 8'h00);
    xfer_bits(8'h00, 8, b);
    chk("id_chip", b, 8'h58);
    cs_high();
    chk("id_oe_off", spi_miso_oe, 0);
    chk("id_miso_off", spi_miso, 0);

    // Calibration burst
    spi_read(8'h88, 24);
    for (int k = 0; k < 24; k++) chk($sformatf("cal[%0d]", k), rbuf[k], cal[k]);

    // Auto-increment wrap 0xFF -> 0x80, reaching 0x88 at the tenth byte
    spi_read(8'hFF, 10);
    chk("wrap_ff", rbuf[0], 8'h00);
    chk("wrap_87", rbuf[8], 8'h00);
    chk("wrap_88", rbuf[9], 8'h70);

    // Forced measurement
    adc_p = 20'h655AC;
    adc_t = 20'h7EED0;
    base = done_pulses;
    spi_write(8'hF4, 8'h25);
    t0 = cyc;
    spi_read(8'hF3, 1);
    chk("forced_status_busy", rbuf[0], 8'h08);
    seen = 1'b0;
    for (int k = 0; k < 2 * MEAS && !seen; k++) begin
      @(negedge clk);
      if (meas_done) seen = 1'b1;
    end
    t1 = cyc;
    chk("forced_done_seen", seen, 1);
    chk("forced_latency", ((t1 - t0) >= int'(MEAS) - 48) && ((t1 - t0) <= int'(MEAS) - 8), 1);
    @(negedge clk);
    chk("forced_done_1cyc", meas_done, 0);
    chk("forced_done_count", done_pulses - base, 1);
    spi_read(8'hF3, 1);
    chk("forced_status_idle", rbuf[0], 8'h00);
    spi_read(8'hF4, 1);
    chk("forced_f4_mode_cleared", rbuf[0], 8'h24);
    chk("forced_ctrl_port", ctrl_meas, 8'h24);
    spi_read(8'hF7, 6);
    chk("forced_f7", rbuf[0], 8'h65);
    chk("forced_f8", rbuf[1], 8'h5A);
    chk("forced_f9", rbuf[2], 8'hC0);
    chk("forced_fa", rbuf[3], 8'h7E);
    chk("forced_fb", rbuf[4], 8'hED);
    chk("forced_fc", rbuf[5], 8'h00);

    // Soft reset
    spi_write(8'hF4, 8'h27);
    spi_write(8'hF5, 8'hFF);
    spi_read(8'hF5, 1);
    chk("cfg_masked", rbuf[0], 8'hFD);
    chk("cfg_port", config_reg, 8'hFD);
    base = srst_pulses;
    spi_write(8'hE0, 8'hB6);
    chk("srst_one_pulse", srst_pulses - base, 1);
    chk("srst_ctrl_port", ctrl_meas, 8'h00);
    chk("srst_cfg_port", config_reg, 8'h00);
    spi_read(8'hF4, 1);
    chk("srst_f4", rbuf[0], 8'h00);
    spi_read(8'hF5, 1);
    chk("srst_f5", rbuf[0], 8'h00);
    spi_read(8'hF7, 3);
    chk("srst_f7", rbuf[0], 8'h80);
    chk("srst_f8", rbuf[1], 8'h00);
    chk("srst_f9", rbuf[2], 8'h00);

    // Shadow: normal-mode completion lands in the middle of the burst
    adc_p = 20'h12345;
    adc_t = 20'hABCDE;
    base = done_pulses;
    spi_write(8'hF4, 8'h27);
    spi_read(8'hF7, 6);
    chk("shadow_done_mid_burst", done_pulses - base, 1);
    chk("shadow_f7", rbuf[0], 8'h80);
    chk("shadow_f8", rbuf[1], 8'h00);
    chk("shadow_f9", rbuf[2], 8'h00);
    chk("shadow_fa", rbuf[3], 8'h80);
    chk("shadow_fb", rbuf[4], 8'h00);
    chk("shadow_fc", rbuf[5], 8'h00);
    spi_read(8'hF7, 6);
    chk("next_f7", rbuf[0], 8'h12);
    chk("next_f8", rbuf[1], 8'h34);
    chk("next_f9", rbuf[2], 8'h50);
    chk("next_fa", rbuf[3], 8'hAB);
    chk("next_fb", rbuf[4], 8'hCD);
    chk("next_fc", rbuf[5], 8'hE0);
    chk("normal_mode_kept", ctrl_meas, 8'h27);
    spi_write(8'hF4, 8'h00);

    // Partial data byte discarded on CSN rise
    spi_write(8'hF4, 8'h24);
    chk("abort_pre_ctrl", ctrl_meas, 8'h24);
    cs_low();
    xfer_bits(8'h74, 8, b);
    xfer_bits(8'hFF, 4, b);
    cs_high();
    chk("abort_ctrl_kept", ctrl_meas, 8'h24);
    chk("abort_oe_off", spi_miso_oe, 0);
    spi_read(8'hD0, 1);
    chk("abort_next_id", rbuf[0], 8'h58);
    spi_read(8'hF4, 1);
    chk("abort_f4_read", rbuf[0], 8'h24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
